// File: rtl/bl_block_serializer.sv
// Backlight block-data serializer: captures one 24x8 frame per start pulse and
// shifts it out MSB-first, block 0 first, over a clock/data/latch link.
module bl_block_serializer #(
    parameter int NUM_BLOCKS = 24,
    parameter int BLK_W      = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iStart,
    input  logic [NUM_BLOCKS*BLK_W-1:0] iBlockData,
    output logic                        oBusy,
    output logic                        oSClk,
    output logic                        oSData,
    output logic                        oLatch,
    output logic                        oDone,
    output logic [1:0]                  oState
);
    localparam int         TOTAL      = NUM_BLOCKS * BLK_W;
    localparam logic [7:0] LAST_BIT   = 8'(TOTAL - 1);
    localparam logic [8:0] DIV_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] DIV_HALF   = 9'(CLK_DIV);
    localparam logic [8:0] LATCH_LAST = 9'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [TOTAL-1:0]   shadow, shadow_nxt;
    logic [7:0]         bit_cnt, bit_nxt;
    logic [8:0]         div_cnt, div_nxt;
    logic               busy_nxt, sclk_nxt, sdata_nxt, latch_nxt, done_nxt;
    logic [7:0]         nxt_bit;
    logic [7:0]         nxt_idx;

    // Start handshake: iStart is a request level sampled every cycle; it is
    // accepted only in IDLE (oBusy=0 and not DONE) and is never queued.
    assign oState  = state;
    assign nxt_bit = bit_cnt + 8'd1;
    // Serial bit n lives at block n/BLK_W, MSB first within the block.
    assign nxt_idx = 8'(BLK_W * (int'(nxt_bit) / BLK_W) + (BLK_W - 1) - int'(nxt_bit) % BLK_W);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            oBusy   <= 1'b0;
            oSClk   <= 1'b0;
            oSData  <= 1'b0;
            oLatch  <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            bit_cnt <= bit_nxt;
            div_cnt <= div_nxt;
            oBusy   <= busy_nxt;
            oSClk   <= sclk_nxt;
            oSData  <= sdata_nxt;
            oLatch  <= latch_nxt;
            oDone   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        bit_nxt    = bit_cnt;
        div_nxt    = div_cnt;
        busy_nxt   = oBusy;
        sclk_nxt   = oSClk;
        sdata_nxt  = oSData;
        latch_nxt  = oLatch;
        done_nxt   = oDone;
        case (state)
            IDLE: begin
                busy_nxt  = 1'b0;
                sclk_nxt  = 1'b0;
                latch_nxt = 1'b0;
                done_nxt  = 1'b0;
                if (iStart) begin
                    shadow_nxt = iBlockData;
                    bit_nxt    = '0;
                    div_nxt    = '0;
                    state_nxt  = SHIFT;
                    busy_nxt   = 1'b1;
                    sdata_nxt  = iBlockData[BLK_W-1];
                end
            end
            SHIFT: begin
                // Data only moves together with the falling edge of oSClk.
                if (div_cnt == DIV_LAST) begin
                    div_nxt  = '0;
                    sclk_nxt = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = LATCH;
                        sdata_nxt = 1'b0;
                        latch_nxt = 1'b1;
                    end else begin
                        bit_nxt   = nxt_bit;
                        sdata_nxt = shadow[nxt_idx];
                    end
                end else begin
                    div_nxt  = div_cnt + 9'd1;
                    sclk_nxt = (9'(div_cnt + 9'd1) >= DIV_HALF);
                end
            end
            LATCH: begin
                if (div_cnt == LATCH_LAST) begin
                    state_nxt = DONE;
                    div_nxt   = '0;
                    latch_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    div_nxt = div_cnt + 9'd1;
                end
            end
            DONE: begin
                done_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
